alu_seq_unit: RTL and testbench

- Parametrised successor to the combinational ALU-control decoder, for the multi-cycle datapath.
- Decodes aluop/funct into a 3-bit operation code, executes it on WIDTH-bit operands, and returns a registered result through a valid/ready handshake.
- Logic ops and add/sub finish in one cycle. SLL/SRL run iteratively, SHIFT_STEP bits per cycle, so no full barrel shifter is needed.
- Sits between the register-read stage and the writeback/controller FSM.

---
 rtl/alu_seq_unit.sv | 184 ++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Sequential ALU for the multi-cycle datapath: decodes aluop/funct, runs the op, returns a held result over valid/ready.
// Logic and add/sub ops finish in one cycle. Logical shifts advance SHIFT_STEP bit positions per cycle.
module alu_seq_unit #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1,
  localparam int SHW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

  // One extra bit so that SHIFT_STEP == WIDTH is representable.
  localparam int             CW     = SHW + 1;
  localparam logic [CW-1:0]  STEP_C = CW'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] wrk_q;
  logic [SHW-1:0]   rem_q;
  logic             shl_q;

  logic [2:0]       dec_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             is_shift;
  logic [CW-1:0]    step;
  logic [SHW-1:0]   rem_d;
  logic [WIDTH-1:0] wrk_d;

  // Operation decode, first matching rule wins.
  always_comb begin
    dec_op = OP_AND;
    if (aluop == 2'b00) begin
      dec_op = OP_ADD;
    end else if (aluop[1]) begin
      dec_op = OP_SUB;
    end else if (funct == 4'b0000) begin
      dec_op = OP_ADD;
    end else if (funct == 4'b0100) begin
      dec_op = OP_SUB;
    end else if (funct[2] && funct[0]) begin
      dec_op = OP_OR;
    end else if (funct[2] && !funct[0]) begin
      dec_op = OP_AND;
    end else if (funct == 4'b0001) begin
      dec_op = OP_SLL;
    end else if (funct == 4'b0010) begin
      dec_op = OP_SRL;
    end else if (funct == 4'b0011) begin
      dec_op = OP_NOR;
    end
  end

  assign is_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL);

  // Single-cycle datapath; a zero-distance shift just passes operand A through.
  always_comb begin
    b_eff   = (dec_op == OP_SUB) ? (~b + WIDTH'(1)) : b;
    sum     = a + b_eff;
    alu_res = a & b;
    alu_ovf = 1'b0;
    case (dec_op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL, OP_SRL: alu_res = a;
      default: alu_res = a & b;
    endcase
  end

  // Per-cycle shift distance is min(SHIFT_STEP, remaining).
  always_comb begin
    step  = ({1'b0, rem_q} > STEP_C) ? STEP_C : {1'b0, rem_q};
    rem_d = rem_q - step[SHW-1:0];
    wrk_d = shl_q ? (wrk_q << step) : (wrk_q >> step);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      op_q        <= OP_AND;
      wrk_q       <= '0;
      rem_q       <= '0;
      shl_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (is_shift && (shamt != '0)) begin
              wrk_q   <= a;
              rem_q   <= shamt;
              shl_q   <= (dec_op == OP_SLL);
              state_q <= S_SHIFT;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              ovf_q       <= alu_ovf;
              op_q        <= dec_op;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          wrk_q <= wrk_d;
          rem_q <= rem_d;
          if (rem_d == '0) begin
            result_q    <= wrk_d;
            zero_q      <= (wrk_d == '0);
            ovf_q       <= 1'b0;
            op_q        <= shl_q ? OP_SLL : OP_SRL;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // Result stays frozen until the consumer takes it.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign op        = op_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomised and directed checks of alu_seq_unit against a behavioural model of the decode/arithmetic rules.
module tb_alu_seq_unit;
  localparam int W    = 32;
  localparam int STEP = 4;
  localparam int SHW  = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     aluop;
  logic [3:0]     funct;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [SHW-1:0] shamt;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   result;
  logic           zero;
  logic           ovf;
  logic [2:0]     op;
  logic           out_valid;
  logic           out_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .aluop(aluop), .funct(funct), .a(a), .b(b),
    .shamt(shamt), .in_valid(in_valid), .in_ready(in_ready), .result(result),
    .zero(zero), .ovf(ovf), .op(op), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Decode table, first match wins.
  function automatic logic [2:0] ref_op(input logic [1:0] ao, input logic [3:0] f);
    if (ao == 2'b00) return 3'b010;
    if (ao[1])       return 3'b110;
    if (f == 4'b0000) return 3'b010;
    if (f == 4'b0100) return 3'b110;
    if (f[2] && f[0])  return 3'b001;
    if (f[2] && !f[0]) return 3'b000;
    if (f == 4'b0001) return 3'b100;
    if (f == 4'b0010) return 3'b101;
    if (f == 4'b0011) return 3'b111;
    return 3'b000;
  endfunction

  function automatic void ref_exec(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input int sh, output logic [W-1:0] r, output logic v);
    logic [W-1:0] yp;
    r = '0;
    v = 1'b0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b111: r = ~(x | y);
      3'b100: r = x << sh;
      3'b101: r = x >> sh;
      default: begin
        yp = (o == 3'b110) ? (0 - y) : y;
        r  = x + yp;
        v  = (x[W-1] == yp[W-1]) && (r[W-1] != x[W-1]);
      end
    endcase
  endfunction

  task automatic scramble();
    a     = $urandom;
    b     = $urandom;
    shamt = SHW'($urandom);
    aluop = 2'($urandom);
    funct = 4'($urandom);
  endtask

  // One request through the handshake, then hold the result for `hold` cycles before taking it.
  task automatic run_txn(input logic [1:0] ao, input logic [3:0] f, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [SHW-1:0] sh, input int hold, input string nm);
    logic [2:0]   eop;
    logic [W-1:0] eres;
    logic         eovf;
    int           elat;
    int           lat;
    eop = ref_op(ao, f);
    ref_exec(eop, x, y, int'(sh), eres, eovf);
    elat = ((eop == 3'b100 || eop == 3'b101) && sh != 0) ? (int'(sh) + STEP - 1) / STEP + 1 : 1;

    @(negedge clk);
    check_eq({nm, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    aluop = ao; funct = f; a = x; b = y; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      check_eq({nm, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      scramble();
      lat++;
      @(negedge clk);
    end
    check_eq({nm, ".latency"}, 32'(lat), 32'(elat));
    check_eq({nm, ".result"}, result, eres);
    check_eq({nm, ".zero"}, 32'(zero), 32'(eres == '0));
    check_eq({nm, ".ovf"}, 32'(ovf), 32'(eovf));
    check_eq({nm, ".op"}, 32'(op), 32'(eop));
    $display("txn %0d %s aluop=%b funct=%b a=%h b=%h sh=%0d -> op=%b res=%h ovf=%b lat=%0d hold=%0d",
             n_txn, nm, ao, f, x, y, sh, op, result, ovf, lat, hold);
    n_txn++;

    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      scramble();
      in_valid = 1'b1;
      @(negedge clk);
      check_eq({nm, ".hold_valid"}, 32'(out_valid), 32'd1);
      check_eq({nm, ".hold_result"}, result, eres);
      check_eq({nm, ".hold_op"}, 32'(op), 32'(eop));
      check_eq({nm, ".hold_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq({nm, ".drain_valid"}, 32'(out_valid), 32'd0);
    check_eq({nm, ".drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    aluop = '0; funct = '0; a = '0; b = '0; shamt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset.out_valid", 32'(out_valid), 32'd0);
    check_eq("reset.in_ready", 32'(in_ready), 32'd1);
    check_eq("reset.result", result, 32'd0);
    check_eq("reset.op", 32'(op), 32'd0);
    check_eq("reset.zero_ovf", {30'd0, zero, ovf}, 32'd0);
    reset = 1'b0;

    run_txn(2'b01, 4'b0000, 32'h7FFF_FFFF, 32'h1, '0, 0, "add_ovf");
    run_txn(2'b10, 4'($urandom), 32'h1234, 32'h1234, '0, 3, "sub_zero");
    run_txn(2'b01, 4'b0001, 32'h1, 32'h0, 5'd10, 0, "sll_10");
    run_txn(2'b01, 4'b0010, 32'hF000_0000, 32'h0, 5'd0, 5, "srl_0");
    run_txn(2'b01, 4'b0111, 32'h0F0F_0F0F, 32'h00FF_00FF, '0, 0, "dec_or");
    run_txn(2'b01, 4'b0110, 32'h0F0F_0F0F, 32'h00FF_00FF, '0, 0, "dec_and");
    run_txn(2'b01, 4'b0011, 32'h0F0F_0F0F, 32'hF0F0_F0F0, '0, 0, "dec_nor");
    run_txn(2'b01, 4'b1000, 32'h0F0F_0F0F, 32'h00FF_00FF, '0, 0, "dec_else");
    run_txn(2'b11, 4'($urandom), 32'h5, 32'h9, '0, 1, "dec_sub11");
    run_txn(2'b01, 4'b0100, 32'h8000_0000, 32'h1, '0, 0, "sub_ovf");
    run_txn(2'b01, 4'b0010, 32'h8000_0000, 32'h0, 5'd31, 1, "srl_31");

    // Reset during the third SHIFT cycle discards the in-flight shift.
    @(negedge clk);
    aluop = 2'b01; funct = 4'b0001; a = 32'h0000_0003; shamt = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid.result", result, 32'd0);
    check_eq("rst_mid.op", 32'(op), 32'd0);
    check_eq("rst_mid.in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("rst_mid.no_stale", 32'(out_valid), 32'd0);
    end

    // Reset wins over a simultaneous request.
    @(negedge clk);
    aluop = 2'b00; a = 32'h1; b = 32'h2; reset = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_req.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_eq("rst_req.no_accept", 32'(out_valid), 32'd0);

    for (int t = 0; t < 150; t++) begin
      logic [1:0] ao;
      logic [3:0] f;
      ao = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
      f  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      run_txn(ao, f, $urandom, $urandom, SHW'($urandom), $urandom_range(0, 3), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
